// File: rtl/cluster_clock_divider.sv
// Programmable integer clock divider feeding the cluster clock mux.
// Ratio updates are committed on a divided-period boundary, so the mux never sees a runt pulse.
module cluster_clock_divider #(
    parameter int DIV_WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 test_mode_i,
    input  logic                 clk_en_i,
    input  logic                 cfg_valid_i,
    output logic                 cfg_ready_o,
    input  logic [DIV_WIDTH-1:0] cfg_div_i,
    output logic                 clk_div_o,
    output logic                 clk_sel_o
);

    localparam logic [DIV_WIDTH-1:0] ONE = DIV_WIDTH'(1);
    localparam logic [DIV_WIDTH-1:0] TWO = DIV_WIDTH'(2);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_END,
        LOAD
    } state_t;

    state_t               state_q, state_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0] pend_q, pend_d;
    logic [DIV_WIDTH-1:0] cnt_run;
    logic [DIV_WIDTH-1:0] last;
    logic                 run;
    logic                 next_bound;
    logic                 clk_q, clk_d;
    logic                 sel_q, sel_d;

    // Free-running counter step; the last count is a boundary where clk_en_i decides wrap or park.
    always_comb begin
        run     = (div_q >= TWO);
        last    = div_q - ONE;
        cnt_run = '0;
        if (run) begin
            if (cnt_q == last) begin
                cnt_run = clk_en_i ? '0 : last;
            end else begin
                cnt_run = cnt_q + ONE;
            end
        end
        next_bound = !run || (cnt_run == last);
    end

    // Config FSM: LOAD lands on the boundary cycle itself, so the new ratio starts seamlessly.
    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        div_d       = div_q;
        cnt_d       = cnt_run;
        cfg_ready_o = 1'b0;
        unique case (state_q)
            IDLE: begin
                cfg_ready_o = 1'b1;
                if (cfg_valid_i) begin
                    pend_d  = cfg_div_i;
                    state_d = WAIT_END;
                end
            end
            WAIT_END: begin
                if (next_bound) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                div_d = pend_q;
                if ((pend_q >= TWO) && !clk_en_i) begin
                    cnt_d = pend_q - ONE;
                end else begin
                    cnt_d = '0;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign clk_d = (div_d >= TWO) && (cnt_d < (div_d >> 1));
    assign sel_d = (div_d >= TWO);

    // State, ratio, counter and registered mux-facing outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            div_q   <= '0;
            cnt_q   <= '0;
            pend_q  <= '0;
            clk_q   <= 1'b0;
            sel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            clk_q   <= clk_d;
            sel_q   <= sel_d;
        end
    end

    assign clk_div_o = clk_q;
    assign clk_sel_o = sel_q & ~test_mode_i;

endmodule

// File: tb/tb_cluster_clock_divider.sv
// Directed bench for cluster_clock_divider.
// Checks {clk_div_o, clk_sel_o, cfg_ready_o} every cycle against hand-computed values.
module tb_cluster_clock_divider;

    logic       clk;
    logic       rst_n;
    logic       test_mode;
    logic       clk_en;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [7:0] cfg_div;
    logic       clk_div;
    logic       clk_sel;

    int n_cmp = 0;
    int n_bad = 0;

    cluster_clock_divider #(.DIV_WIDTH(8)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .test_mode_i (test_mode),
        .clk_en_i    (clk_en),
        .cfg_valid_i (cfg_valid),
        .cfg_ready_o (cfg_ready),
        .cfg_div_i   (cfg_div),
        .clk_div_o   (clk_div),
        .clk_sel_o   (clk_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       tm;
        logic       en;
        logic       v;
        logic [7:0] d;
        logic       eclk;
        logic       esel;
        logic       erdy;
    } vec_t;

    vec_t tbl[32];

    task automatic chk(input string nm, input int cyc, input logic [2:0] exp);
        logic [2:0] act;
        act = {clk_div, clk_sel, cfg_ready};
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc %0d: clk/sel/rdy got %b want %b",
                     nm, cyc, act, exp);
        end
    endtask

    // Hold inputs for n cycles; expected bit strings are read MSB first.
    task automatic seq(input string nm, input int n,
                       input logic en, input logic tm,
                       input logic v, input logic [7:0] d,
                       input logic [15:0] ec,
                       input logic [15:0] es,
                       input logic [15:0] er);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            clk_en    = en;
            test_mode = tm;
            cfg_valid = v;
            cfg_div   = d;
            #1;
            chk(nm, i, {ec[n-1-i], es[n-1-i], er[n-1-i]});
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        clk_en    = 1'b1;
        test_mode = 1'b0;
        cfg_valid = 1'b0;
        cfg_div   = 8'd0;
        #1;
        chk("rst", 0, 3'b001);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_rel", 0, 3'b001);
    endtask

    // Write a ratio from bypass/IDLE: accept, then WAIT_END and LOAD.
    task automatic load_from_bypass(input string nm, input logic [7:0] n);
        seq(nm, 1, 1'b1, 1'b0, 1'b1, n, 16'b0, 16'b0, 16'b1);
        seq(nm, 2, 1'b1, 1'b0, 1'b0, 8'd0, 16'b00, 16'b00, 16'b00);
    endtask

    initial begin
        rst_n     = 1'b0;
        test_mode = 1'b0;
        clk_en    = 1'b1;
        cfg_valid = 1'b0;
        cfg_div   = 8'd0;

        // rst tm en v d clk sel rdy
        tbl[0]  = '{0, 0, 1, 0, 8'd0, 0, 0, 1};
        tbl[1]  = '{1, 0, 1, 0, 8'd0, 0, 0, 1};
        tbl[2]  = '{1, 0, 1, 1, 8'd4, 0, 0, 1};
        tbl[3]  = '{1, 0, 1, 0, 8'd0, 0, 0, 0};
        tbl[4]  = '{1, 0, 1, 0, 8'd0, 0, 0, 0};
        tbl[5]  = '{1, 0, 1, 0, 8'd0, 1, 1, 1};
        tbl[6]  = '{1, 0, 1, 0, 8'd0, 1, 1, 1};
        tbl[7]  = '{1, 0, 1, 0, 8'd0, 0, 1, 1};
        tbl[8]  = '{1, 0, 1, 0, 8'd0, 0, 1, 1};
        tbl[9]  = '{1, 0, 1, 0, 8'd0, 1, 1, 1};
        tbl[10] = '{1, 0, 1, 0, 8'd0, 1, 1, 1};
        tbl[11] = '{1, 0, 1, 0, 8'd0, 0, 1, 1};
        tbl[12] = '{1, 0, 1, 0, 8'd0, 0, 1, 1};
        tbl[13] = '{1, 0, 1, 0, 8'd0, 1, 1, 1};
        tbl[14] = '{1, 0, 1, 1, 8'd5, 1, 1, 1};
        tbl[15] = '{1, 0, 1, 0, 8'd0, 0, 1, 0};
        tbl[16] = '{1, 0, 1, 0, 8'd0, 0, 1, 0};
        tbl[17] = '{1, 0, 1, 0, 8'd0, 1, 1, 1};
        tbl[18] = '{1, 0, 1, 0, 8'd0, 1, 1, 1};
        tbl[19] = '{1, 0, 1, 0, 8'd0, 0, 1, 1};
        tbl[20] = '{1, 0, 1, 0, 8'd0, 0, 1, 1};
        tbl[21] = '{1, 0, 1, 0, 8'd0, 0, 1, 1};
        tbl[22] = '{1, 0, 1, 0, 8'd0, 1, 1, 1};
        tbl[23] = '{1, 0, 1, 0, 8'd0, 1, 1, 1};
        tbl[24] = '{1, 0, 1, 0, 8'd0, 0, 1, 1};
        tbl[25] = '{1, 0, 1, 0, 8'd0, 0, 1, 1};
        tbl[26] = '{1, 0, 1, 0, 8'd0, 0, 1, 1};
        tbl[27] = '{1, 0, 1, 0, 8'd0, 1, 1, 1};
        tbl[28] = '{1, 0, 1, 0, 8'd0, 1, 1, 1};
        tbl[29] = '{0, 0, 1, 0, 8'd0, 0, 0, 1};
        tbl[30] = '{1, 0, 1, 0, 8'd0, 0, 0, 1};
        tbl[31] = '{1, 0, 1, 0, 8'd0, 0, 0, 1};

        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            rst_n     = tbl[i].rst;
            test_mode = tbl[i].tm;
            clk_en    = tbl[i].en;
            cfg_valid = tbl[i].v;
            cfg_div   = tbl[i].d;
            #1;
            chk("tbl", i, {tbl[i].eclk, tbl[i].esel, tbl[i].erdy});
        end

        // N=3, then switch to bypass at cnt0, then N=2
        load_from_bypass("w3", 8'd3);
        seq("n3", 6, 1, 0, 0, 8'd0, 16'b100100, 16'b111111, 16'b111111);
        seq("w1", 1, 1, 0, 1, 8'd1, 16'b1, 16'b1, 16'b1);
        seq("to_byp", 4, 1, 0, 0, 8'd0, 16'b0000, 16'b1100, 16'b0011);
        load_from_bypass("w2", 8'd2);
        seq("n2", 6, 1, 0, 0, 8'd0, 16'b101010, 16'b111111, 16'b111111);

        // Gating at N=4
        do_reset();
        load_from_bypass("w4", 8'd4);
        seq("gate", 10, 0, 0, 0, 8'd0,
            16'b1100000000, 16'b1111111111, 16'b1111111111);
        seq("ungate", 7, 1, 0, 0, 8'd0,
            16'b0110011, 16'b1111111, 16'b1111111);
        seq("midgate", 1, 0, 0, 0, 8'd0, 16'b0, 16'b1, 16'b1);
        seq("mid_en", 3, 1, 0, 0, 8'd0, 16'b011, 16'b111, 16'b111);

        // Test mode at N=6, then a held same-ratio write
        do_reset();
        load_from_bypass("w6", 8'd6);
        seq("tm0", 2, 1, 0, 0, 8'd0, 16'b11, 16'b11, 16'b11);
        seq("tm1", 2, 1, 1, 0, 8'd0, 16'b10, 16'b00, 16'b11);
        seq("tm0b", 2, 1, 0, 0, 8'd0, 16'b00, 16'b11, 16'b11);
        seq("rewr", 12, 1, 0, 1, 8'd6,
            16'b111000111000, 16'b111111111111, 16'b100000100000);
        seq("after", 6, 1, 0, 0, 8'd0, 16'b111000, 16'b111111, 16'b111111);

        // Largest ratio: 127 high, 128 low, then wrap
        do_reset();
        load_from_bypass("w255", 8'd255);
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            clk_en    = 1'b1;
            cfg_valid = 1'b0;
            #1;
            chk("n255", i, {((i % 255) < 127), 1'b1, 1'b1});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cluster_clock_divider.md
Name: cluster_clock_divider

Overview:
- Programmable integer clock divider that directly feeds the cluster clock mux.
- Drives the mux's divided-clock input (clk_div_o) and its select input (clk_sel_o).
- Mux undivided input is clk_i itself; when the block is in bypass, clk_sel_o=0 so the mux passes clk_i.
- Divide-ratio changes go through a valid/ready handshake and take effect only at a divided-period boundary, so no runt pulses reach the mux.

Parameters:
- DIV_WIDTH, 8, width of divide-ratio field and internal counter.

Ports:
- clk_i  in  1  source clock; all state on rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- test_mode_i  in  1  1 forces clk_sel_o=0 (mux passes clk_i); internal state unaffected.
- clk_en_i  in  1  divided-clock enable, sampled at period boundary.
- cfg_valid_i  in  1  new divide ratio presented.
- cfg_ready_o  out  1  block can accept a ratio.
- cfg_div_i  in  DIV_WIDTH  requested ratio N; 0 or 1 means bypass.
- clk_div_o  out  1  registered divided clock to mux clk1_i.
- clk_sel_o  out  1  mux select; 1 selects clk_div_o.

Behaviour:
Reset (async, rst_ni=0, also mid-operation)
- div_q=0 (bypass), cnt=0, FSM=IDLE.
- clk_div_o=0, clk_sel_o=0, cfg_ready_o=1.

Run mode (div_q=N≥2)
- cnt counts 0..N-1, then wraps.
- clk_div_o is a register: high while cnt<floor(N/2), low otherwise.
- Resulting pattern: floor(N/2) high, ceil(N/2) low (odd N gets the longer low phase).
- Period boundary: cycle with cnt==N-1.
- Max N = 2^DIV_WIDTH-1; counter arithmetic is unsigned DIV_WIDTH with no overflow.

Bypass (div_q≤1)
- cnt held 0, clk_div_o=0, clk_sel_o=0 (clk_sel_o is registered).
- Every cycle counts as a boundary.
- clk_en_i is ignored in bypass; gating belongs downstream.

Gating
- clk_en_i is sampled only at a boundary.
- If 0: cnt parks at N-1 and clk_div_o stays 0.
- The parked state is re-checked each cycle; on the first cycle clk_en_i=1, cnt wraps to 0 and clk_div_o goes high the following cycle.
- clk_en_i changes between boundaries have no effect.

Output select
- clk_sel_o = sel_q AND NOT test_mode_i.
- sel_q is a register, 1 iff div_q≥2.

Config FSM
- IDLE: cfg_ready_o=1. On cfg_valid_i & cfg_ready_o, capture cfg_div_i into pend_q and go to WAIT_END.
- WAIT_END: cfg_ready_o=0. Leave at a boundary where clk_div_o is 0 (parked counts), go to LOAD. In bypass this exits in the first WAIT_END cycle.
- LOAD: cfg_ready_o=0, one cycle.
  - div_q<=pend_q, sel_q<=(pend_q≥2), cnt<=0.
  - If new N≥2 and clk_en_i=1, clk_div_o<=1 in the cycle after LOAD; otherwise park as in Gating.
  - Go to IDLE.
- Accept-to-IDLE latency: minimum 2 cycles in bypass, maximum N+1 in run.
- cfg_valid_i must hold with stable data until accepted. While cfg_ready_o=0 it is ignored, with no queueing.
- Re-writing the same N still takes the WAIT_END/LOAD path; the waveform stays seamless (phase restarts exactly at the boundary).
- Switching from run to bypass: clk_sel_o falls in the same cycle that clk_div_o would begin a new high phase. clk_div_o is already 0, so the mux sees no partial pulse.
- Reset in WAIT_END or LOAD discards pend_q.

Test Plan:
1. Assert rst_ni=0 mid-run at N=4 (cnt=1) → same-cycle clk_div_o=0, clk_sel_o=0, cfg_ready_o=1; after release the block stays in bypass.
2. From reset, write cfg_div_i=4 → handshake completes in 1 cycle, cfg_ready_o low 2 cycles, then clk_sel_o=1 and clk_div_o=1,1,0,0 repeating for 20 cycles.
3. Running N=4, write N=5 at cnt=1 → current 1100 period completes, then 1,1,0,0,0 repeating; no high phase shorter than 2; cfg_ready_o returns 1 at most 5 cycles after accept.
4. Running N=3, write N=1 → after the boundary clk_sel_o=0 and clk_div_o=0 with no extra high cycle; a second write of N=2 completes in 2 cycles and produces 1,0 repeating.
5. N=4, drop clk_en_i for 10 cycles starting at cnt=0 → clk_div_o finishes 1,1,0,0 then stays 0. Raise clk_en_i → clk_div_o high for exactly 2 cycles starting the cycle after re-enable is seen.
6. N=6 running, toggle test_mode_i → clk_sel_o follows test_mode_i combinationally, clk_div_o pattern 111000 continues undisturbed; a cfg write held while cfg_ready_o=0 is accepted only once cfg_ready_o returns to 1.
